// File: rtl/partition_sweep_pkg.sv
`default_nettype none
// ============================================================================
// Module      : partition_sweep_pkg
// Description : Shared types and width helpers for the exhaustive partition
//               sweep checker (FSM state encoding, accumulator widths).
// Revision    : 1.0 - initial release
// ============================================================================
package partition_sweep_pkg;

    // Sweep controller states, explicitly 2 bits wide.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } sweep_state_t;

    // Bits needed to hold a popcount of a num_out-bit vector (0..num_out).
    function automatic int popcnt_width(input int num_out);
        return $clog2(num_out + 1);
    endfunction

    // Bit-flip total: up to 2^num_in vectors, each contributing at most num_out.
    function automatic int bit_err_width(input int num_in, input int num_out);
        return num_in + 1 + $clog2(num_out + 1);
    endfunction

    // Settle counter runs 0..settle_cycles-1; never narrower than one bit.
    function automatic int settle_cnt_width(input int settle_cycles);
        return (settle_cycles < 2) ? 1 : $clog2(settle_cycles);
    endfunction

endpackage
`default_nettype wire

// File: rtl/partition_sweep_checker_err_metric.sv
`default_nettype none
// ============================================================================
// Module      : err_metric_unit
// Description : Combinational error metrics between an exact and an
//               approximate partition output.
//   i_exact    - exact partition output
//   i_approx   - approximate partition output
//   o_mismatch - outputs differ
//   o_popcnt   - number of differing bits (Hamming distance)
//   o_abs_diff - unsigned |exact - approx|
// Revision    : 1.0 - initial release
// ============================================================================
module err_metric_unit
    import partition_sweep_pkg::*;
#(
    parameter int WIDTH = 3,
    parameter int PC_W  = popcnt_width(WIDTH)
) (
    input  logic [WIDTH-1:0] i_exact,
    input  logic [WIDTH-1:0] i_approx,
    output logic             o_mismatch,
    output logic [PC_W-1:0]  o_popcnt,
    output logic [WIDTH-1:0] o_abs_diff
);

    logic [WIDTH-1:0] w_diff;

    always_comb begin
        w_diff   = i_exact ^ i_approx;
        o_popcnt = '0;
        for (int i = 0; i < WIDTH; i++) begin
            o_popcnt = o_popcnt + PC_W'(w_diff[i]);
        end
    end

    assign o_mismatch = |w_diff;
    // Subtract the smaller from the larger so the result never wraps.
    assign o_abs_diff = (i_exact >= i_approx) ? (i_exact - i_approx)
                                              : (i_approx - i_exact);

endmodule
`default_nettype wire

// File: rtl/partition_sweep_checker.sv
`default_nettype none
// ============================================================================
// Module      : partition_sweep_checker
// Description : Drives every input vector 0..2^NUM_IN-1 into an exact and an
//               approximate logic partition, holds each vector SETTLE_CYCLES
//               cycles, samples both outputs for one cycle and accumulates
//               error metrics.
//   clk, rst_n       - clock, synchronous active-low reset
//   start            - pulse that begins a sweep (ignored while busy)
//   pi               - vector driven to both partitions
//   exact_po         - exact partition output
//   approx_po        - approximate partition output
//   busy / done      - sweep in progress / sweep finished (held)
//   vec_count        - vectors evaluated
//   err_count        - vectors with exact_po != approx_po
//   bit_err_count    - sum of Hamming distances
//   max_err_dist     - worst unsigned |exact_po - approx_po|
//   first_fail_vec   - lowest failing vector (valid with fail_seen)
//   fail_seen        - at least one mismatch in this sweep
// Revision    : 1.0 - initial release
// ============================================================================
module partition_sweep_checker
    import partition_sweep_pkg::*;
#(
    parameter int NUM_IN        = 5,
    parameter int NUM_OUT       = 3,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic                                       clk,
    input  logic                                       rst_n,
    input  logic                                       start,
    output logic [NUM_IN-1:0]                          pi,
    input  logic [NUM_OUT-1:0]                         exact_po,
    input  logic [NUM_OUT-1:0]                         approx_po,
    output logic                                       busy,
    output logic                                       done,
    output logic [NUM_IN:0]                            vec_count,
    output logic [NUM_IN:0]                            err_count,
    output logic [bit_err_width(NUM_IN, NUM_OUT)-1:0]  bit_err_count,
    output logic [NUM_OUT-1:0]                         max_err_dist,
    output logic [NUM_IN-1:0]                          first_fail_vec,
    output logic                                       fail_seen
);

    localparam int c_BE_W  = bit_err_width(NUM_IN, NUM_OUT);
    localparam int c_PC_W  = popcnt_width(NUM_OUT);
    localparam int c_CNT_W = settle_cnt_width(SETTLE_CYCLES);
    localparam logic [c_CNT_W-1:0] c_SETTLE_LAST = c_CNT_W'(SETTLE_CYCLES - 1);

    sweep_state_t        r_state;
    sweep_state_t        w_next_state;
    logic [c_CNT_W-1:0]  r_cnt;
    logic [NUM_IN-1:0]   r_pi;
    logic [NUM_IN:0]     r_vec;
    logic [NUM_IN:0]     r_err;
    logic [c_BE_W-1:0]   r_bit;
    logic [NUM_OUT-1:0]  r_max;
    logic [NUM_IN-1:0]   r_first;
    logic                r_fail;

    logic                w_mismatch;
    logic [c_PC_W-1:0]   w_popcnt;
    logic [NUM_OUT-1:0]  w_abs_diff;
    logic                w_start_accept;
    logic                w_settle_last;
    logic                w_last_vec;

    err_metric_unit #(
        .WIDTH (NUM_OUT),
        .PC_W  (c_PC_W)
    ) u_metric (
        .i_exact    (exact_po),
        .i_approx   (approx_po),
        .o_mismatch (w_mismatch),
        .o_popcnt   (w_popcnt),
        .o_abs_diff (w_abs_diff)
    );

    // A start pulse only counts when no sweep is running.
    assign w_start_accept = start && ((r_state == IDLE) || (r_state == DONE));
    assign w_settle_last  = (r_cnt == c_SETTLE_LAST);
    assign w_last_vec     = &r_pi;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (start) w_next_state = SETTLE;
            SETTLE:  if (w_settle_last) w_next_state = CAPTURE;
            CAPTURE: w_next_state = w_last_vec ? DONE : SETTLE;
            DONE:    if (start) w_next_state = SETTLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        busy = (r_state == SETTLE) || (r_state == CAPTURE);
        done = (r_state == DONE);
    end

    // Vector register, settle counter and accumulators
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_pi    <= '0;
            r_vec   <= '0;
            r_err   <= '0;
            r_bit   <= '0;
            r_max   <= '0;
            r_first <= '0;
            r_fail  <= 1'b0;
        end else if (w_start_accept) begin
            r_cnt   <= '0;
            r_pi    <= '0;
            r_vec   <= '0;
            r_err   <= '0;
            r_bit   <= '0;
            r_max   <= '0;
            r_first <= '0;
            r_fail  <= 1'b0;
        end else begin
            case (r_state)
                SETTLE: begin
                    if (!w_settle_last) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                CAPTURE: begin
                    r_vec <= r_vec + 1'b1;
                    if (w_mismatch) begin
                        r_err <= r_err + 1'b1;
                        r_bit <= r_bit + c_BE_W'(w_popcnt);
                        // Vectors are swept upward, so the first mismatch
                        // is also the lowest failing vector.
                        if (!r_fail) begin
                            r_fail  <= 1'b1;
                            r_first <= r_pi;
                        end
                    end
                    if (w_abs_diff > r_max) begin
                        r_max <= w_abs_diff;
                    end
                    // The final vector stays on pi once the sweep is done.
                    if (!w_last_vec) begin
                        r_pi  <= r_pi + 1'b1;
                        r_cnt <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign pi             = r_pi;
    assign vec_count      = r_vec;
    assign err_count      = r_err;
    assign bit_err_count  = r_bit;
    assign max_err_dist   = r_max;
    assign first_fail_vec = r_first;
    assign fail_seen      = r_fail;

endmodule
`default_nettype wire

// File: tb/tb_partition_sweep_checker.sv
`default_nettype none
// ============================================================================
// Module      : tb_partition_sweep_checker
// Description : Self-checking bench for partition_sweep_checker. The two
//               partitions are truth tables held in the bench; expected
//               metrics come from a straight loop over those tables.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_partition_sweep_checker;

    logic clk    = 1'b0;
    logic rst_n  = 1'b0;
    logic start  = 1'b0;
    logic start2 = 1'b0;
    always #5 clk = ~clk;

    // Default instance: NUM_IN=5, NUM_OUT=3, SETTLE_CYCLES=1
    logic [4:0] pi;
    logic [2:0] exact_po, approx_po, max_err_dist;
    logic       busy, done, fail_seen;
    logic [5:0] vec_count, err_count;
    logic [7:0] bit_err_count;
    logic [4:0] first_fail_vec;

    // Second instance: NUM_IN=4, NUM_OUT=3, SETTLE_CYCLES=3
    logic [3:0] pi2;
    logic [2:0] exact_po2, approx_po2, max_err_dist2;
    logic       busy2, done2, fail_seen2;
    logic [4:0] vec_count2, err_count2;
    logic [6:0] bit_err_count2;
    logic [3:0] first_fail_vec2;

    logic [2:0] ex1 [32];
    logic [2:0] ap1 [32];
    logic [2:0] ex2 [16];
    logic [2:0] ap2 [16];

    assign exact_po   = ex1[pi];
    assign approx_po  = ap1[pi];
    assign exact_po2  = ex2[pi2];
    assign approx_po2 = ap2[pi2];

    partition_sweep_checker dut (
        .clk(clk), .rst_n(rst_n), .start(start), .pi(pi),
        .exact_po(exact_po), .approx_po(approx_po), .busy(busy), .done(done),
        .vec_count(vec_count), .err_count(err_count), .bit_err_count(bit_err_count),
        .max_err_dist(max_err_dist), .first_fail_vec(first_fail_vec), .fail_seen(fail_seen)
    );

    partition_sweep_checker #(.NUM_IN(4), .NUM_OUT(3), .SETTLE_CYCLES(3)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .pi(pi2),
        .exact_po(exact_po2), .approx_po(approx_po2), .busy(busy2), .done(done2),
        .vec_count(vec_count2), .err_count(err_count2), .bit_err_count(bit_err_count2),
        .max_err_dist(max_err_dist2), .first_fail_vec(first_fail_vec2), .fail_seen(fail_seen2)
    );

    int n_run  = 0;
    int n_fail = 0;

    // Reference results
    int e_vec, e_err, e_bit, e_max, e_first, e_fail;
    logic [28:0] exp_pack;

    // Observations recorded by run1
    int   cyc;
    logic first_busy, first_done;
    logic [4:0] first_pi;
    logic [5:0] first_vec;

    // Fill the truth tables: 0 exact==approx, 1 lsb flipped, 2 approx stuck
    // at zero, 3 fully random, 4 sparse random faults.
    task automatic fill(input int mode);
        for (int v = 0; v < 32; v++) begin
            ex1[v] = (mode >= 3) ? 3'($urandom) : 3'(v);
            case (mode)
                0:       ap1[v] = ex1[v];
                1:       ap1[v] = ex1[v] ^ 3'b001;
                2:       ap1[v] = 3'b000;
                3:       ap1[v] = 3'($urandom);
                default: ap1[v] = ex1[v] ^ (($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b000);
            endcase
            if (v < 16) begin
                ex2[v] = 3'($urandom);
                ap2[v] = ex2[v] ^ (($urandom_range(0, 2) == 0) ? 3'($urandom) : 3'b000);
            end
        end
    endtask

    // Metrics computed directly from the definitions over the whole table.
    task automatic model(input int sel);
        int n, ex, ap, d;
        n = sel ? 16 : 32;
        e_vec = n; e_err = 0; e_bit = 0; e_max = 0; e_first = 0; e_fail = 0;
        for (int v = 0; v < n; v++) begin
            ex = sel ? int'(ex2[v]) : int'(ex1[v]);
            ap = sel ? int'(ap2[v]) : int'(ap1[v]);
            d  = (ex > ap) ? ex - ap : ap - ex;
            if (d > e_max) e_max = d;
            if (ex != ap) begin
                e_err++;
                e_bit += $countones(ex ^ ap);
                if (e_fail == 0) begin e_fail = 1; e_first = v; end
            end
        end
        exp_pack = {6'(e_vec), 6'(e_err), 8'(e_bit), 3'(e_max), 5'(e_first), 1'(e_fail)};
    endtask

    // Pulse start on dut, then count cycles until done (bounded). Optional
    // extra start pulses are raised at cycle numbers xa / xb of the sweep.
    task automatic run1(input int xa, input int xb);
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        first_busy = busy; first_done = done; first_pi = pi; first_vec = vec_count;
        cyc = 0;
        while (!done && cyc < 500) begin
            start = (cyc == xa) || (cyc == xb);
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_run++;
        if ({busy, done, fail_seen, pi, vec_count, err_count, bit_err_count, max_err_dist, first_fail_vec} !== '0) begin
            n_fail++;
            $display("FAIL reset_state: got busy=%b done=%b pi=%0d vec=%0d err=%0d bit=%0d max=%0d first=%0d fail=%b, required all 0",
                     busy, done, pi, vec_count, err_count, bit_err_count, max_err_dist, first_fail_vec, fail_seen);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_run++;
        if ({busy, done, pi} !== '0) begin
            n_fail++;
            $display("FAIL idle_hold: got busy=%b done=%b pi=%0d, required 0 0 0", busy, done, pi);
        end
    endtask

    task automatic test_sweep(input string name, input int mode);
        fill(mode);
        model(0);
        run1(-1, -1);
        n_run++;
        if (first_busy !== 1'b1 || first_pi !== 5'd0 || first_done !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_start: got busy=%b pi=%0d done=%b, required 1 0 0", name, first_busy, first_pi, first_done);
        end
        n_run++;
        if (cyc !== 64) begin
            n_fail++;
            $display("FAIL %s_latency: got %0d cycles, required 64", name, cyc);
        end
        n_run++;
        if ({vec_count, err_count, bit_err_count, max_err_dist, first_fail_vec, fail_seen} !== exp_pack) begin
            n_fail++;
            $display("FAIL %s_metrics: got vec=%0d err=%0d bit=%0d max=%0d first=%0d fail=%b, required vec=%0d err=%0d bit=%0d max=%0d first=%0d fail=%0d",
                     name, vec_count, err_count, bit_err_count, max_err_dist, first_fail_vec, fail_seen,
                     e_vec, e_err, e_bit, e_max, e_first, e_fail);
        end
        n_run++;
        if (busy !== 1'b0 || pi !== 5'd31) begin
            n_fail++;
            $display("FAIL %s_end: got busy=%b pi=%0d, required 0 31", name, busy, pi);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 3; i++) test_sweep("random", (i == 1) ? 4 : 3);
    endtask

    task automatic test_start_mid_sweep();
        fill(4);
        model(0);
        // Extra pulses mid-sweep and in the cycle whose edge raises done.
        run1(30, 63);
        n_run++;
        if (cyc !== 64) begin
            n_fail++;
            $display("FAIL midstart_latency: got %0d cycles, required 64", cyc);
        end
        @(posedge clk); #1;
        n_run++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL midstart_done_held: got done=%b busy=%b, required 1 0", done, busy);
        end
        n_run++;
        if ({vec_count, err_count, bit_err_count, max_err_dist, first_fail_vec, fail_seen} !== exp_pack) begin
            n_fail++;
            $display("FAIL midstart_metrics: got vec=%0d err=%0d bit=%0d max=%0d first=%0d, required vec=%0d err=%0d bit=%0d max=%0d first=%0d",
                     vec_count, err_count, bit_err_count, max_err_dist, first_fail_vec, e_vec, e_err, e_bit, e_max, e_first);
        end
    endtask

    task automatic test_reset_mid_sweep();
        fill(3);
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (21) @(posedge clk);
        #1;
        n_run++;
        if (vec_count !== 6'd10 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_reset_progress: got vec=%0d busy=%b, required 10 1", vec_count, busy);
        end
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        n_run++;
        if ({busy, done, fail_seen, pi, vec_count, err_count, bit_err_count, max_err_dist, first_fail_vec} !== '0) begin
            n_fail++;
            $display("FAIL midreset_clear: got busy=%b done=%b pi=%0d vec=%0d err=%0d bit=%0d max=%0d first=%0d fail=%b, required all 0",
                     busy, done, pi, vec_count, err_count, bit_err_count, max_err_dist, first_fail_vec, fail_seen);
        end
        repeat (3) @(posedge clk);
        #1;
        n_run++;
        if ({busy, done, pi, vec_count} !== '0) begin
            n_fail++;
            $display("FAIL midreset_idle: got busy=%b done=%b pi=%0d vec=%0d, required 0 0 0 0", busy, done, pi, vec_count);
        end
    endtask

    task automatic test_back_to_back();
        logic [28:0] held;
        fill(2);
        model(0);
        run1(-1, -1);
        repeat (5) @(posedge clk);
        #1;
        held = {vec_count, err_count, bit_err_count, max_err_dist, first_fail_vec, fail_seen};
        n_run++;
        if (held !== exp_pack || done !== 1'b1) begin
            n_fail++;
            $display("FAIL done_stable: got metrics=%h done=%b, required %h 1", held, done, exp_pack);
        end
        fill(1);
        model(0);
        run1(-1, -1);
        n_run++;
        if (first_done !== 1'b0 || first_busy !== 1'b1 || first_vec !== 6'd0) begin
            n_fail++;
            $display("FAIL restart_clear: got done=%b busy=%b vec=%0d, required 0 1 0", first_done, first_busy, first_vec);
        end
        n_run++;
        if (cyc !== 64) begin
            n_fail++;
            $display("FAIL restart_latency: got %0d cycles, required 64", cyc);
        end
        n_run++;
        if ({vec_count, err_count, bit_err_count, max_err_dist, first_fail_vec, fail_seen} !== exp_pack) begin
            n_fail++;
            $display("FAIL restart_metrics: got vec=%0d err=%0d bit=%0d max=%0d first=%0d, required vec=%0d err=%0d bit=%0d max=%0d first=%0d",
                     vec_count, err_count, bit_err_count, max_err_dist, first_fail_vec, e_vec, e_err, e_bit, e_max, e_first);
        end
    endtask

    task automatic test_settle();
        int   c;
        logic held_ok;
        fill(3);
        model(1);
        @(posedge clk); #1 start2 = 1'b1;
        @(posedge clk); #1 start2 = 1'b0;
        c = 0;
        held_ok = 1'b1;
        while (!done2 && c < 500) begin
            if (pi2 !== 4'(c / 4)) held_ok = 1'b0;
            @(posedge clk); #1;
            c++;
        end
        n_run++;
        if (c !== 64) begin
            n_fail++;
            $display("FAIL settle3_latency: got %0d cycles, required 64", c);
        end
        n_run++;
        if (held_ok !== 1'b1) begin
            n_fail++;
            $display("FAIL settle3_pi_hold: got hold_ok=%b, required 1", held_ok);
        end
        n_run++;
        if (vec_count2 !== 5'(e_vec) || err_count2 !== 5'(e_err) || bit_err_count2 !== 7'(e_bit) ||
            max_err_dist2 !== 3'(e_max) || first_fail_vec2 !== 4'(e_first) || fail_seen2 !== 1'(e_fail)) begin
            n_fail++;
            $display("FAIL settle3_metrics: got vec=%0d err=%0d bit=%0d max=%0d first=%0d fail=%b, required vec=%0d err=%0d bit=%0d max=%0d first=%0d fail=%0d",
                     vec_count2, err_count2, bit_err_count2, max_err_dist2, first_fail_vec2, fail_seen2,
                     e_vec, e_err, e_bit, e_max, e_first, e_fail);
        end
    endtask

    initial begin
        fill(0);
        test_reset();
        test_sweep("exact_match", 0);
        test_sweep("lsb_flip", 1);
        test_sweep("approx_zero", 2);
        test_random();
        test_start_mid_sweep();
        test_reset_mid_sweep();
        test_back_to_back();
        test_settle();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
